// File: rtl/regfile_scoreboard.sv
// ---------------------------------------------------------------------------
// regfile_scoreboard
//
// Integer register file for the pipelined RV32IM core. It has NUM_READ
// combinational read ports, x0 hardwired to zero, and a write-to-read bypass.
// A per-register pending-write scoreboard lets decode detect RAW hazards.
// A dump engine streams the whole file out over a valid/ready channel.
//
// Ports
//   CLK, RESET      clock (rising edge); asynchronous active-high reset
//   RD_ADRS         packed read addresses, port k at [k*ADDR_WIDTH +: ADDR_WIDTH]
//   RD_DATA         packed read data,      port k at [k*DATA_WIDTH +: DATA_WIDTH]
//   RD_BUSY         port k's register has an outstanding (unbypassed) write
//   WRITE_ENABLE    writeback strobe
//   WB_ADDRESS      writeback destination
//   WRITE_DATA      writeback value
//   ISSUE_VALID     an instruction with a destination issued this cycle
//   ISSUE_ADDRESS   destination of the issued instruction
//   DUMP_START      request a full-file dump (ignored while streaming)
//   DUMP_VALID      dump beat valid
//   DUMP_READY      consumer accepts the beat
//   DUMP_INDEX      register index of the current beat
//   DUMP_DATA       register value of the current beat (live array contents)
//   DUMP_LAST       current beat is the last register
//   DUMP_ACTIVE     dump engine is streaming
// ---------------------------------------------------------------------------
module regfile_scoreboard #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 5,
   parameter int NUM_READ   = 2
) (
   input  logic                           CLK,
   input  logic                           RESET,
   input  logic [NUM_READ*ADDR_WIDTH-1:0] RD_ADRS,
   output logic [NUM_READ*DATA_WIDTH-1:0] RD_DATA,
   output logic [NUM_READ-1:0]            RD_BUSY,
   input  logic                           WRITE_ENABLE,
   input  logic [ADDR_WIDTH-1:0]          WB_ADDRESS,
   input  logic [DATA_WIDTH-1:0]          WRITE_DATA,
   input  logic                           ISSUE_VALID,
   input  logic [ADDR_WIDTH-1:0]          ISSUE_ADDRESS,
   input  logic                           DUMP_START,
   output logic                           DUMP_VALID,
   input  logic                           DUMP_READY,
   output logic [ADDR_WIDTH-1:0]          DUMP_INDEX,
   output logic [DATA_WIDTH-1:0]          DUMP_DATA,
   output logic                           DUMP_LAST,
   output logic                           DUMP_ACTIVE
);

   localparam int                    DEPTH      = 2 ** ADDR_WIDTH;
   localparam logic [ADDR_WIDTH-1:0] LAST_INDEX = '1;

   typedef enum logic {
      IDLE   = 1'b0,
      STREAM = 1'b1
   } dump_state_t;

   logic [DATA_WIDTH-1:0] r_regs [DEPTH];
   logic [DEPTH-1:0]      r_busy;

   dump_state_t           r_state;
   logic [ADDR_WIDTH-1:0] r_dump_index;
   logic                  r_dump_valid;
   logic                  r_dump_last;

   logic                  w_wb_write;
   logic [ADDR_WIDTH-1:0] w_next_index;

   assign w_wb_write   = WRITE_ENABLE && (WB_ADDRESS != '0);
   assign w_next_index = r_dump_index + ADDR_WIDTH'(1);

   // ------------------------------------------------------------------
   // Register array
   // ------------------------------------------------------------------
   // NOTE: the array is reset because the architectural state must read as
   // zero after RESET; entry 0 is never written, which keeps x0 at zero.
   // NOTE: state is updated with non-blocking assignments so every flop
   // samples pre-edge values, independent of block ordering.
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         for (int i = 0; i < DEPTH; i++) begin
            r_regs[i] <= '0;
         end
      end else if (w_wb_write) begin
         r_regs[WB_ADDRESS] <= WRITE_DATA;
      end
   end

   // ------------------------------------------------------------------
   // Scoreboard: issue sets, writeback clears. When both hit the same
   // register on one edge the set wins, because the newly issued producer
   // is still outstanding. Bit 0 is never set.
   // ------------------------------------------------------------------
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         r_busy <= '0;
      end else begin
         for (int i = 1; i < DEPTH; i++) begin
            if (ISSUE_VALID && (ISSUE_ADDRESS == ADDR_WIDTH'(i))) begin
               r_busy[i] <= 1'b1;
            end else if (WRITE_ENABLE && (WB_ADDRESS == ADDR_WIDTH'(i))) begin
               r_busy[i] <= 1'b0;
            end
         end
      end
   end

   // ------------------------------------------------------------------
   // Read ports: x0 reads zero, and a same-cycle writeback is forwarded.
   // A forwarded value is final, so the port does not report busy.
   // ------------------------------------------------------------------
   for (genvar k = 0; k < NUM_READ; k++) begin : g_rd
      logic [ADDR_WIDTH-1:0] w_rd_addr;
      logic                  w_rd_bypass;

      assign w_rd_addr   = RD_ADRS[k*ADDR_WIDTH +: ADDR_WIDTH];
      assign w_rd_bypass = WRITE_ENABLE && (WB_ADDRESS == w_rd_addr);

      assign RD_DATA[k*DATA_WIDTH +: DATA_WIDTH] =
         (w_rd_addr == '0) ? '0         :
         w_rd_bypass       ? WRITE_DATA :
                             r_regs[w_rd_addr];

      assign RD_BUSY[k] = (w_rd_addr != '0) && r_busy[w_rd_addr] && !w_rd_bypass;
   end

   // ------------------------------------------------------------------
   // Dump engine. VALID and LAST are registered together with the state.
   // DATA is read live from the array, so a write that lands during a
   // stall is visible at the accepting edge.
   // ------------------------------------------------------------------
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         r_state      <= IDLE;
         r_dump_index <= '0;
         r_dump_valid <= 1'b0;
         r_dump_last  <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (DUMP_START) begin
                  r_state      <= STREAM;
                  r_dump_index <= '0;
                  r_dump_valid <= 1'b1;
                  r_dump_last  <= (LAST_INDEX == '0);
               end
            end
            STREAM: begin
               if (DUMP_READY) begin
                  if (r_dump_index == LAST_INDEX) begin
                     r_state      <= IDLE;
                     r_dump_index <= '0;
                     r_dump_valid <= 1'b0;
                     r_dump_last  <= 1'b0;
                  end else begin
                     r_dump_index <= w_next_index;
                     r_dump_last  <= (w_next_index == LAST_INDEX);
                  end
               end
            end
         endcase
      end
   end

   assign DUMP_VALID  = r_dump_valid;
   assign DUMP_INDEX  = r_dump_index;
   assign DUMP_DATA   = r_regs[r_dump_index];
   assign DUMP_LAST   = r_dump_last;
   assign DUMP_ACTIVE = (r_state == STREAM);

endmodule

// File: tb/tb_regfile_scoreboard.sv
// ---------------------------------------------------------------------------
// tb_regfile_scoreboard
//
// Directed bench for regfile_scoreboard with default parameters
// (32-bit data, 32 registers, 2 read ports). Inputs change 1 time unit after
// the rising edge, and outputs are checked 3 time units after the edge.
// ---------------------------------------------------------------------------
module tb_regfile_scoreboard;

   localparam int DW = 32;
   localparam int AW = 5;
   localparam int NR = 2;

   logic             clk;
   logic             reset;
   logic [NR*AW-1:0] rd_adrs;
   logic [NR*DW-1:0] rd_data;
   logic [NR-1:0]    rd_busy;
   logic             write_enable;
   logic [AW-1:0]    wb_address;
   logic [DW-1:0]    write_data;
   logic             issue_valid;
   logic [AW-1:0]    issue_address;
   logic             dump_start;
   logic             dump_valid;
   logic             dump_ready;
   logic [AW-1:0]    dump_index;
   logic [DW-1:0]    dump_data;
   logic             dump_last;
   logic             dump_active;

   int n_checks = 0;
   int n_errors = 0;

   regfile_scoreboard #(
      .DATA_WIDTH(DW),
      .ADDR_WIDTH(AW),
      .NUM_READ  (NR)
   ) dut (
      .CLK          (clk),
      .RESET        (reset),
      .RD_ADRS      (rd_adrs),
      .RD_DATA      (rd_data),
      .RD_BUSY      (rd_busy),
      .WRITE_ENABLE (write_enable),
      .WB_ADDRESS   (wb_address),
      .WRITE_DATA   (write_data),
      .ISSUE_VALID  (issue_valid),
      .ISSUE_ADDRESS(issue_address),
      .DUMP_START   (dump_start),
      .DUMP_VALID   (dump_valid),
      .DUMP_READY   (dump_ready),
      .DUMP_INDEX   (dump_index),
      .DUMP_DATA    (dump_data),
      .DUMP_LAST    (dump_last),
      .DUMP_ACTIVE  (dump_active)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #2;
   endtask

   task automatic set_rd(input logic [AW-1:0] a0, input logic [AW-1:0] a1);
      rd_adrs = {a1, a0};
   endtask

   function automatic logic [DW-1:0] rd(input int k);
      return rd_data[k*DW +: DW];
   endfunction

   task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
      write_enable = 1'b1;
      wb_address   = a;
      write_data   = d;
      tick();
      write_enable = 1'b0;
   endtask

   task automatic start_dump();
      dump_start = 1'b1;
      tick();
      dump_start = 1'b0;
   endtask

   initial begin
      reset         = 1'b1;
      rd_adrs       = '0;
      write_enable  = 1'b0;
      wb_address    = '0;
      write_data    = '0;
      issue_valid   = 1'b0;
      issue_address = '0;
      dump_start    = 1'b0;
      dump_ready    = 1'b0;
      tick();
      tick();
      reset = 1'b0;
      tick();

      // ---- reset asserted mid-operation ----
      wr(5'd3, 32'h1111_2222);
      issue_valid   = 1'b1;
      issue_address = 5'd3;
      tick();
      issue_valid   = 1'b0;
      set_rd(5'd3, 5'd3);
      settle();
      check("pre_reset_busy_x3", rd_busy[0], 1'b1);
      reset = 1'b1;
      #1;
      check("async_reset_rd0", rd(0), 32'h0);
      tick();
      reset = 1'b0;
      settle();
      check("reset_rd0", rd(0), 32'h0);
      check("reset_rd1", rd(1), 32'h0);
      check("reset_busy", rd_busy, 2'b00);
      check("reset_dump_valid", dump_valid, 1'b0);
      check("reset_dump_index", dump_index, 5'd0);
      check("reset_dump_last", dump_last, 1'b0);
      check("reset_dump_active", dump_active, 1'b0);

      // ---- basic write/read ----
      wr(5'd5, 32'hDEAD_BEEF);
      set_rd(5'd5, 5'd0);
      settle();
      check("read_x5", rd(0), 32'hDEAD_BEEF);

      // ---- x0 is hardwired ----
      write_enable = 1'b1;
      wb_address   = 5'd0;
      write_data   = 32'h1234_5678;
      set_rd(5'd0, 5'd0);
      settle();
      check("x0_no_bypass_p0", rd(0), 32'h0);
      check("x0_no_bypass_p1", rd(1), 32'h0);
      tick();
      write_enable = 1'b0;
      settle();
      check("x0_after_write_p0", rd(0), 32'h0);
      check("x0_after_write_p1", rd(1), 32'h0);
      issue_valid   = 1'b1;
      issue_address = 5'd0;
      tick();
      issue_valid = 1'b0;
      settle();
      check("x0_never_busy", rd_busy, 2'b00);

      // ---- same-cycle bypass ----
      wr(5'd3, 32'h0000_0033);
      write_enable = 1'b1;
      wb_address   = 5'd7;
      write_data   = 32'hA5A5_A5A5;
      set_rd(5'd3, 5'd7);
      settle();
      check("bypass_p1_x7", rd(1), 32'hA5A5_A5A5);
      check("bypass_p0_x3", rd(0), 32'h0000_0033);
      tick();
      write_enable = 1'b0;
      settle();
      check("stored_x7", rd(1), 32'hA5A5_A5A5);

      // ---- scoreboard ----
      issue_valid   = 1'b1;
      issue_address = 5'd9;
      tick();
      issue_valid = 1'b0;
      set_rd(5'd9, 5'd10);
      settle();
      check("busy_after_issue_x9", rd_busy[0], 1'b1);
      write_enable = 1'b1;
      wb_address   = 5'd9;
      write_data   = 32'h0000_0099;
      settle();
      check("busy_bypassed_x9", rd_busy[0], 1'b0);
      check("data_bypassed_x9", rd(0), 32'h0000_0099);
      tick();
      write_enable = 1'b0;
      settle();
      check("busy_cleared_x9", rd_busy[0], 1'b0);
      // issue and writeback on the same register and edge: set wins
      issue_valid   = 1'b1;
      issue_address = 5'd9;
      write_enable  = 1'b1;
      wb_address    = 5'd9;
      write_data    = 32'h0000_0999;
      tick();
      issue_valid  = 1'b0;
      write_enable = 1'b0;
      settle();
      check("busy_set_wins_x9", rd_busy[0], 1'b1);
      // issue x10 while x9 writes back: independent
      issue_valid   = 1'b1;
      issue_address = 5'd10;
      write_enable  = 1'b1;
      wb_address    = 5'd9;
      write_data    = 32'h0000_0009;
      tick();
      issue_valid  = 1'b0;
      write_enable = 1'b0;
      settle();
      check("indep_x9_clear", rd_busy[0], 1'b0);
      check("indep_x10_set", rd_busy[1], 1'b1);

      // ---- full dump ----
      for (int i = 1; i < 32; i++) wr(AW'(i), DW'(i * 3));
      dump_ready = 1'b1;
      start_dump();
      for (int b = 0; b < 32; b++) begin
         settle();
         check($sformatf("dump_valid_%0d", b), dump_valid, 1'b1);
         check($sformatf("dump_active_%0d", b), dump_active, 1'b1);
         check($sformatf("dump_index_%0d", b), dump_index, 32'(b));
         check($sformatf("dump_data_%0d", b), dump_data, 32'(b * 3));
         check($sformatf("dump_last_%0d", b), dump_last, (b == 31) ? 1'b1 : 1'b0);
         tick();
      end
      settle();
      check("dump_done_valid", dump_valid, 1'b0);
      check("dump_done_active", dump_active, 1'b0);
      check("dump_done_index", dump_index, 5'd0);

      // ---- dump with stall, then reset mid-dump ----
      start_dump();
      for (int b = 0; b < 4; b++) begin
         settle();
         check($sformatf("dump2_index_%0d", b), dump_index, 32'(b));
         tick();
      end
      dump_ready = 1'b0;
      settle();
      check("stall_index_a", dump_index, 5'd4);
      check("stall_data_a", dump_data, 32'd12);
      wr(5'd4, 32'h0000_0055);
      settle();
      check("stall_index_b", dump_index, 5'd4);
      check("stall_data_b", dump_data, 32'h0000_0055);
      tick();
      settle();
      check("stall_index_c", dump_index, 5'd4);
      tick();
      settle();
      check("stall_index_d", dump_index, 5'd4);
      check("stall_valid", dump_valid, 1'b1);
      dump_ready = 1'b1;
      settle();
      check("accept_data_x4", dump_data, 32'h0000_0055);
      tick();
      settle();
      check("after_stall_index", dump_index, 5'd5);
      for (int b = 5; b < 10; b++) tick();
      settle();
      check("pre_reset_index", dump_index, 5'd10);
      reset = 1'b1;
      set_rd(5'd4, 5'd7);
      #1;
      check("abort_valid", dump_valid, 1'b0);
      check("abort_active", dump_active, 1'b0);
      check("abort_regs_x4", rd(0), 32'h0);
      check("abort_regs_x7", rd(1), 32'h0);
      tick();
      reset = 1'b0;
      tick();
      tick();
      settle();
      check("no_beats_after_abort", dump_valid, 1'b0);
      check("index_after_abort", dump_index, 5'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
